// File: rtl/discrete_log_pkg.sv
// Shared types and helpers for the log-domain level-detection blocks.
// Levels are signed Q8.8 natural-log values.
package discrete_log_pkg;

  typedef logic signed [15:0] q8_8_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    UPDATE
  } lef_state_t;

  localparam q8_8_t LN_FLOOR_DEFAULT = -16'sd2048;

  function automatic q8_8_t sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return q8_8_t'(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/log_one_pole_step.sv
// One-pole smoothing step in the log domain: fast attack with a guaranteed
// minimum step, release frozen while the hold counter is running.
module log_one_pole_step
  import discrete_log_pkg::*;
#(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input  q8_8_t              env,
  input  q8_8_t              x,
  input  logic               hold_zero,
  output logic signed [16:0] step,
  output logic               attack
);

  logic signed [16:0] d;
  logic signed [16:0] atk_step;
  logic signed [16:0] rel_step;

  always_comb begin
    d        = {x[15], x} - {env[15], env};
    atk_step = d >>> ATTACK_SHIFT;
    rel_step = d >>> RELEASE_SHIFT;
    attack   = (d > 17'sd0);
    step     = 17'sd0;
    if (attack) begin
      // A positive difference must always move the envelope, or it would
      // stall just below the input once d < 2^ATTACK_SHIFT.
      step = (atk_step == 17'sd0) ? 17'sd1 : atk_step;
    end else if (hold_zero) begin
      step = rel_step;
    end
  end

endmodule

// File: rtl/log_envelope_follower.sv
// Log-domain peak envelope follower: waits for the ln stage latency, captures
// one ln sample per audio strobe and emits one smoothed Q8.8 level.
module log_envelope_follower
  import discrete_log_pkg::*;
#(
  parameter int    LOG_LATENCY   = 2,
  parameter int    ATTACK_SHIFT  = 2,
  parameter int    RELEASE_SHIFT = 8,
  parameter int    HOLD_SAMPLES  = 16,
  parameter q8_8_t FLOOR         = LN_FLOOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_clk,
  input  q8_8_t      ln_in,
  input  logic       clear_overrun,
  output q8_8_t      env_out,
  output logic       env_valid,
  output logic       overrun,
  output lef_state_t state_dbg
);

  localparam logic [3:0] WAIT_LOAD = 4'(LOG_LATENCY - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_SAMPLES);

  lef_state_t         state;
  logic [3:0]         wait_cnt;
  logic [7:0]         hold_cnt;
  q8_8_t              x_q;
  q8_8_t              x_clamped;
  q8_8_t              env_sat;
  q8_8_t              env_next;
  logic signed [16:0] step;
  logic signed [16:0] env_sum;
  logic               attack;
  logic               drop;

  log_one_pole_step #(
    .ATTACK_SHIFT (ATTACK_SHIFT),
    .RELEASE_SHIFT(RELEASE_SHIFT)
  ) u_step (
    .env      (env_out),
    .x        (x_q),
    .hold_zero(hold_cnt == 8'd0),
    .step     (step),
    .attack   (attack)
  );

  always_comb begin
    x_clamped = (ln_in < FLOOR) ? FLOOR : ln_in;
    env_sum   = {env_out[15], env_out} + step;
    env_sat   = sat16(env_sum);
    env_next  = (env_sat < FLOOR) ? FLOOR : env_sat;
    drop      = sample_clk && ((state == WAIT) || (state == CAPTURE));
  end

  assign state_dbg = state;

  // valid/ready contract: sample_clk is accepted only in IDLE or UPDATE;
  // a strobe seen in WAIT or CAPTURE is dropped and flagged via overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      hold_cnt  <= 8'd0;
      x_q       <= FLOOR;
      env_out   <= FLOOR;
      env_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      env_valid <= 1'b0;
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      case (state)
        WAIT: begin
          // Sample ln_in on the last WAIT cycle, exactly LOG_LATENCY
          // clocks after the strobe.
          if (wait_cnt == 4'd0) begin
            x_q   <= x_clamped;
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          env_out   <= env_next;
          env_valid <= 1'b1;
          if (attack) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end
          state <= UPDATE;
        end
        default: begin
          if (sample_clk) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
